// File: rtl/ex_pkg.sv
// Shared definitions for the MIPS32 execute stage: bus widths, operation codes,
// result classes and the divider state encoding.
package ex_pkg;

    localparam int AluOpBus     = 8;
    localparam int AluSelBus    = 3;
    localparam int RegBus       = 32;
    localparam int RegAddrBus   = 5;
    localparam int DoubleRegBus = 64;

    localparam logic [RegBus-1:0] ZeroWord = 32'h0000_0000;

    localparam logic [AluOpBus-1:0] EXE_NOP_OP   = 8'b0000_0000;
    localparam logic [AluOpBus-1:0] EXE_AND_OP   = 8'b0010_0100;
    localparam logic [AluOpBus-1:0] EXE_OR_OP    = 8'b0010_0101;
    localparam logic [AluOpBus-1:0] EXE_XOR_OP   = 8'b0010_0110;
    localparam logic [AluOpBus-1:0] EXE_NOR_OP   = 8'b0010_0111;
    localparam logic [AluOpBus-1:0] EXE_SLL_OP   = 8'b0111_1100;
    localparam logic [AluOpBus-1:0] EXE_SRL_OP   = 8'b0000_0010;
    localparam logic [AluOpBus-1:0] EXE_SRA_OP   = 8'b0000_0011;
    localparam logic [AluOpBus-1:0] EXE_ADD_OP   = 8'b0010_0000;
    localparam logic [AluOpBus-1:0] EXE_ADDU_OP  = 8'b0010_0001;
    localparam logic [AluOpBus-1:0] EXE_SUB_OP   = 8'b0010_0010;
    localparam logic [AluOpBus-1:0] EXE_SUBU_OP  = 8'b0010_0011;
    localparam logic [AluOpBus-1:0] EXE_SLT_OP   = 8'b0010_1010;
    localparam logic [AluOpBus-1:0] EXE_SLTU_OP  = 8'b0010_1011;
    localparam logic [AluOpBus-1:0] EXE_MFHI_OP  = 8'b0001_0000;
    localparam logic [AluOpBus-1:0] EXE_MTHI_OP  = 8'b0001_0001;
    localparam logic [AluOpBus-1:0] EXE_MFLO_OP  = 8'b0001_0010;
    localparam logic [AluOpBus-1:0] EXE_MTLO_OP  = 8'b0001_0011;
    localparam logic [AluOpBus-1:0] EXE_MULT_OP  = 8'b0001_1000;
    localparam logic [AluOpBus-1:0] EXE_MULTU_OP = 8'b0001_1001;
    localparam logic [AluOpBus-1:0] EXE_DIV_OP   = 8'b0001_1010;
    localparam logic [AluOpBus-1:0] EXE_DIVU_OP  = 8'b0001_1011;

    localparam logic [AluSelBus-1:0] EXE_RES_NOP   = 3'b000;
    localparam logic [AluSelBus-1:0] EXE_RES_LOGIC = 3'b001;
    localparam logic [AluSelBus-1:0] EXE_RES_SHIFT = 3'b010;
    localparam logic [AluSelBus-1:0] EXE_RES_MOVE  = 3'b011;
    localparam logic [AluSelBus-1:0] EXE_RES_ARITH = 3'b100;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'b00,
        DIV_BUSY = 2'b01,
        DIV_DONE = 2'b10
    } div_state_e;

    function automatic logic [RegBus-1:0] abs32(input logic [RegBus-1:0] v);
        return v[RegBus-1] ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/ex_div.sv
// Iterative 32-step restoring divider for DIV/DIVU; operands are sampled only
// when leaving IDLE, result is valid while ready=1 (one cycle in DONE).
module div_unit
    import ex_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    signed_div,
    input  logic [RegBus-1:0]       op1,
    input  logic [RegBus-1:0]       op2,
    input  logic                    start,
    output logic [DoubleRegBus-1:0] result,
    output logic                    ready
);

    div_state_e        state_q, state_d;
    logic [RegBus-1:0] rem_q, rem_d;
    logic [RegBus-1:0] quo_q, quo_d;
    logic [RegBus-1:0] dvs_q, dvs_d;
    logic [4:0]        cnt_q, cnt_d;
    logic              neg_quo_q, neg_quo_d;
    logic              neg_rem_q, neg_rem_d;
    logic [RegBus:0]   partial;
    logic [RegBus:0]   diff;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= DIV_IDLE;
            rem_q     <= ZeroWord;
            quo_q     <= ZeroWord;
            dvs_q     <= ZeroWord;
            cnt_q     <= 5'd0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            dvs_q     <= dvs_d;
            cnt_q     <= cnt_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        dvs_d     = dvs_q;
        cnt_d     = cnt_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        ready     = 1'b0;
        // quotient register doubles as the dividend shift register
        partial   = {rem_q, quo_q[RegBus-1]};
        diff      = partial - {1'b0, dvs_q};

        case (state_q)
            DIV_IDLE: begin
                if (start) begin
                    if (op2 == ZeroWord) begin
                        // divide-by-zero lands directly in the result registers
                        rem_d     = op1;
                        quo_d     = 32'hFFFF_FFFF;
                        neg_quo_d = 1'b0;
                        neg_rem_d = 1'b0;
                        state_d   = DIV_DONE;
                    end else begin
                        rem_d     = ZeroWord;
                        quo_d     = signed_div ? abs32(op1) : op1;
                        dvs_d     = signed_div ? abs32(op2) : op2;
                        neg_quo_d = signed_div & (op1[RegBus-1] ^ op2[RegBus-1]);
                        neg_rem_d = signed_div & op1[RegBus-1];
                        cnt_d     = 5'd0;
                        state_d   = DIV_BUSY;
                    end
                end
            end
            DIV_BUSY: begin
                if (!diff[RegBus]) begin
                    rem_d = diff[RegBus-1:0];
                    quo_d = {quo_q[RegBus-2:0], 1'b1};
                end else begin
                    rem_d = partial[RegBus-1:0];
                    quo_d = {quo_q[RegBus-2:0], 1'b0};
                end
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd31) begin
                    state_d = DIV_DONE;
                end
            end
            DIV_DONE: begin
                ready   = 1'b1;
                state_d = DIV_IDLE;
            end
            default: begin
                state_d = DIV_IDLE;
            end
        endcase
    end

    assign result = {(neg_rem_q ? (~rem_q + 32'd1) : rem_q),
                     (neg_quo_q ? (~quo_q + 32'd1) : quo_q)};

endmodule

// File: rtl/ex.sv
// MIPS32 execute stage: combinational ALU/shift/compare/multiply datapath,
// output muxing toward EX/MEM, and the stall request for the iterative divider.
module ex
    import ex_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic [AluOpBus-1:0]   aluop_i,
    input  logic [AluSelBus-1:0]  alusel_i,
    input  logic [RegBus-1:0]     reg1_i,
    input  logic [RegBus-1:0]     reg2_i,
    input  logic [RegAddrBus-1:0] wd_i,
    input  logic                  wreg_i,
    input  logic [RegBus-1:0]     hi_i,
    input  logic [RegBus-1:0]     lo_i,
    output logic [RegAddrBus-1:0] wd_o,
    output logic                  wreg_o,
    output logic [RegBus-1:0]     wdata_o,
    output logic                  whilo_o,
    output logic [RegBus-1:0]     hi_o,
    output logic [RegBus-1:0]     lo_o,
    output logic                  stallreq_o
);

    logic [RegBus-1:0]       logic_res;
    logic [RegBus-1:0]       shift_res;
    logic [RegBus-1:0]       arith_res;
    logic [RegBus-1:0]       move_res;
    logic [RegBus-1:0]       sum;
    logic [RegBus-1:0]       sub;
    logic                    ov;
    logic [DoubleRegBus-1:0] mul_a;
    logic [DoubleRegBus-1:0] mul_b;
    logic [DoubleRegBus-1:0] mul_res;
    logic                    is_div;
    logic                    div_ready;
    logic [DoubleRegBus-1:0] div_res;

    always_comb begin
        logic_res = ZeroWord;
        case (aluop_i)
            EXE_AND_OP: logic_res = reg1_i & reg2_i;
            EXE_OR_OP:  logic_res = reg1_i | reg2_i;
            EXE_XOR_OP: logic_res = reg1_i ^ reg2_i;
            EXE_NOR_OP: logic_res = ~(reg1_i | reg2_i);
            default:    logic_res = ZeroWord;
        endcase
    end

    always_comb begin
        shift_res = ZeroWord;
        case (aluop_i)
            EXE_SLL_OP: shift_res = reg2_i << reg1_i[4:0];
            EXE_SRL_OP: shift_res = reg2_i >> reg1_i[4:0];
            EXE_SRA_OP: shift_res = $signed(reg2_i) >>> reg1_i[4:0];
            default:    shift_res = ZeroWord;
        endcase
    end

    assign sum = reg1_i + reg2_i;
    assign sub = reg1_i - reg2_i;

    always_comb begin
        arith_res = ZeroWord;
        ov        = 1'b0;
        case (aluop_i)
            EXE_ADD_OP: begin
                arith_res = sum;
                ov = (reg1_i[31] == reg2_i[31]) && (sum[31] != reg1_i[31]);
            end
            EXE_ADDU_OP: arith_res = sum;
            EXE_SUB_OP: begin
                arith_res = sub;
                ov = (reg1_i[31] != reg2_i[31]) && (sub[31] != reg1_i[31]);
            end
            EXE_SUBU_OP: arith_res = sub;
            EXE_SLT_OP:  arith_res = {31'd0, ($signed(reg1_i) < $signed(reg2_i))};
            EXE_SLTU_OP: arith_res = {31'd0, (reg1_i < reg2_i)};
            default:     arith_res = ZeroWord;
        endcase
    end

    always_comb begin
        move_res = ZeroWord;
        case (aluop_i)
            EXE_MFHI_OP: move_res = hi_i;
            EXE_MFLO_OP: move_res = lo_i;
            default:     move_res = ZeroWord;
        endcase
    end

    // the low 64 bits of the extended product give both signed and unsigned results
    assign mul_a   = (aluop_i == EXE_MULT_OP) ? {{32{reg1_i[31]}}, reg1_i} : {32'd0, reg1_i};
    assign mul_b   = (aluop_i == EXE_MULT_OP) ? {{32{reg2_i[31]}}, reg2_i} : {32'd0, reg2_i};
    assign mul_res = mul_a * mul_b;

    assign is_div = (aluop_i == EXE_DIV_OP) || (aluop_i == EXE_DIVU_OP);

    div_unit u_div (
        .clk        (clk),
        .rst        (rst),
        .signed_div (aluop_i == EXE_DIV_OP),
        .op1        (reg1_i),
        .op2        (reg2_i),
        .start      (is_div),
        .result     (div_res),
        .ready      (div_ready)
    );

    always_comb begin
        wd_o       = '0;
        wreg_o     = 1'b0;
        wdata_o    = ZeroWord;
        whilo_o    = 1'b0;
        hi_o       = ZeroWord;
        lo_o       = ZeroWord;
        stallreq_o = 1'b0;
        if (!rst) begin
            wd_o   = wd_i;
            wreg_o = wreg_i & ~ov;
            case (alusel_i)
                EXE_RES_LOGIC: wdata_o = logic_res;
                EXE_RES_SHIFT: wdata_o = shift_res;
                EXE_RES_ARITH: wdata_o = arith_res;
                EXE_RES_MOVE:  wdata_o = move_res;
                EXE_RES_NOP:   wdata_o = ZeroWord;
                default:       wdata_o = ZeroWord;
            endcase
            case (aluop_i)
                EXE_MTHI_OP: begin
                    whilo_o = 1'b1;
                    hi_o    = reg1_i;
                    lo_o    = lo_i;
                end
                EXE_MTLO_OP: begin
                    whilo_o = 1'b1;
                    hi_o    = hi_i;
                    lo_o    = reg1_i;
                end
                EXE_MULT_OP, EXE_MULTU_OP: begin
                    whilo_o = 1'b1;
                    wreg_o  = 1'b0;
                    {hi_o, lo_o} = mul_res;
                end
                EXE_DIV_OP, EXE_DIVU_OP: begin
                    stallreq_o = ~div_ready;
                    if (div_ready) begin
                        whilo_o = 1'b1;
                        {hi_o, lo_o} = div_res;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: doc/ex.md
# ex

Execute stage of the five-stage MIPS32 integer pipeline. It sits directly downstream of the ID/EX pipeline register and consumes its decoded operation, operand values and destination fields. It produces the GPR write-back triple and the HI/LO write request for the EX/MEM register. Single-cycle ALU, shift, compare and multiply operations resolve combinationally. DIV/DIVU run in an iterative 32-step divider that stalls the pipeline through `stallreq_o`.

## Interface
Parameters:
- none; all widths come from the shared definitions: `AluOpBus` 8, `AluSelBus` 3, `RegBus` 32, `RegAddrBus` 5, `DoubleRegBus` 64.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- aluop_i  in  8  operation code (`EXE_*_OP`).
- alusel_i  in  3  result class: `EXE_RES_NOP/LOGIC/SHIFT/ARITH/MOVE`.
- reg1_i, reg2_i  in  32  operands. For shifts, reg1_i[4:0] is the shift amount and reg2_i is the value shifted.
- wd_i  in  5  destination GPR.
- wreg_i  in  1  GPR write request.
- hi_i, lo_i  in  32  current HI/LO, already forwarded from MEM/WB.
- wd_o  out  5  = wd_i.
- wreg_o  out  1  GPR write enable.
- wdata_o  out  32  GPR write data.
- whilo_o  out  1  HI/LO write enable.
- hi_o, lo_o  out  32  HI/LO write data.
- stallreq_o  out  1  request to hold the IF, ID and ID/EX stages.

## Operation
- While rst=1, all outputs are 0 and the divider state is IDLE. Only the divider registers are sequential.
- Logic ops: AND, OR, XOR, NOR.
- Shift ops: SLL, SRL, SRA, using shamt = reg1_i[4:0].
- Arithmetic ops:
  - ADD, ADDU, SUB, SUBU, SLT, SLTU.
  - SLT is a signed compare; SLTU is unsigned. The result is zero-extended 0/1.
  - ADD/SUB signed overflow forces wreg_o=0; wdata_o is don't-care.
- Move ops: MFHI/MFLO put hi_i/lo_i on wdata_o.
- MTHI: whilo_o=1, hi_o=reg1_i, lo_o=lo_i.
- MTLO: whilo_o=1, lo_o=reg1_i, hi_o=hi_i.
- MULT/MULTU: full 64-bit product, signed or unsigned, computed combinationally. {hi_o,lo_o}=product, whilo_o=1, wreg_o=0.
- DIV/DIVU use an FSM with states IDLE, BUSY, DONE:
  - IDLE: on a DIV op with divisor≠0, latch |dividend| and |divisor| (raw values for DIVU), clear count, go to BUSY; stallreq_o=1.
  - IDLE: on a DIV op with divisor==0, go to DONE; stallreq_o=1.
  - BUSY: one restoring shift-subtract step per cycle; count 0→31. After step 31, go to DONE; stallreq_o=1 throughout.
  - DONE: stallreq_o=0, whilo_o=1, hi_o=remainder, lo_o=quotient; then go to IDLE unconditionally.
  - Signed sign fix: the quotient is negated when the operand signs differ; the remainder takes the dividend's sign.
  - Divide-by-zero result: lo_o=0xFFFFFFFF, hi_o=dividend.
- Unknown aluop or EXE_RES_NOP: wdata_o=0. wreg_o passes wreg_i unless overflow suppresses it. whilo_o=0.

## Timing
- Non-divide ops have zero internal latency: outputs settle in the same cycle the ID/EX register presents the instruction.
- DIV entering EX at cycle 0:
  - stallreq_o is high in cycles 0..32.
  - The result is on the outputs and stallreq_o=0 in cycle 33; EX/MEM captures it at the end of cycle 33.
- Divide-by-zero entering EX at cycle 0: stallreq_o is high in cycle 0 only; the result appears in cycle 1.
- The pipeline control holds the ID/EX inputs stable while stallreq_o=1. The divider samples its operands only on the IDLE→BUSY transition.
- A DIV directly following a DIV starts cleanly, because DONE always returns to IDLE.
- rst during BUSY or DONE returns to IDLE on the next edge; no stall or partial result survives reset.

## Structure
- `EXE_*_OP`, `EXE_RES_*`, bus widths, `ZeroWord` and the divider state encoding belong in the shared definitions package.
- The divider is a separate sub-module, `div_unit`, with this interface:
  - inputs: clk, rst, signed_div, op1, op2, start.
  - outputs: result[63:0], ready.
- `ex` keeps only the combinational datapath, output muxing and the stall logic.

## Test plan
- AND/OR/NOR with 0xF0F0F0F0, 0x0FF00FF0: wdata_o = 0x00F000F0, 0xFFF0FFF0 and 0x000F000F respectively; wreg_o=1.
- SRA reg1=4, reg2=0x80000000 → 0xF8000000.
- ADD 0x7FFFFFFF+1 → wreg_o=0.
- SLT -1 vs 1 → 1; SLTU -1 vs 1 → 0.
- MULT 0xFFFFFFFF×2 → hi_o=0xFFFFFFFF, lo_o=0xFFFFFFFE. MULTU with the same operands → hi_o=1, lo_o=0xFFFFFFFE.
- DIV -7/2: stallreq_o high for exactly 33 cycles, then lo_o=0xFFFFFFFD, hi_o=0xFFFFFFFF, whilo_o=1. DIVU 7/0 → stall 1 cycle, lo_o=0xFFFFFFFF, hi_o=7.
- Assert rst at cycle 10 of a DIV → stallreq_o=0 and whilo_o=0 after the edge; a following DIVU 100/7 yields lo_o=14, hi_o=2.
